dmem_ctrl: RTL

//  Data-memory controller directly downstream of the core's data port.
//  - Consumes DIR_DMEM/DATA_WRITE_DMEM/READ/WRITE plus funct3.
//  - Steers each access to on-chip synchronous RAM or to the memory-mapped IO window.
//  - Performs byte/half/word lane steering and load sign/zero extension.
//  - Returns DATA_READ_DMEM, and holds the core with STALL until load/IO data is ready.

---
 rtl/dmem_ctrl_if.sv | 21 ++
 rtl/dmem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Core-side data-port bundle between the core (master) and dmem_ctrl (slave).
interface dmem_ctrl_if;
    logic        READ;
    logic        WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] DIR_DMEM;
    logic [31:0] DATA_WRITE_DMEM;
    logic [31:0] DATA_READ_DMEM;
    logic        STALL;
    logic        ERR;

    modport master (
        output READ, WRITE, FUNCT3, DIR_DMEM, DATA_WRITE_DMEM,
        input  DATA_READ_DMEM, STALL, ERR
    );

    modport slave (
        input  READ, WRITE, FUNCT3, DIR_DMEM, DATA_WRITE_DMEM,
        output DATA_READ_DMEM, STALL, ERR
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: steers core loads/stores to on-chip RAM or the IO window, with lane steering and load extension.
// Optional feature macro: DMEM_MISALIGN_EN (misaligned accesses trap instead of being force-aligned).
module dmem_ctrl #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] IO_BASE = 32'h0001_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RSTa,
    dmem_ctrl_if.slave        core,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [31:0]       RAM_WDATA,
    output logic [3:0]        RAM_BE,
    output logic              RAM_WE,
    output logic              RAM_RE,
    input  logic [31:0]       RAM_RDATA,
    output logic              IO_REQ,
    output logic              IO_WE,
    output logic [7:0]        IO_ADDR,
    output logic [31:0]       IO_WDATA,
    output logic [3:0]        IO_BE,
    input  logic [31:0]       IO_RDATA,
    input  logic              IO_ACK
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RAM_RD  = 2'b01,
        IO_WAIT = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        f3_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;

    logic [2:0]        f3_s;
    logic [31:0]       addr_s;
    logic [31:0]       wd_s;
    logic [3:0]        be_s;
    logic [31:0]       wrep_s;
    logic              req_s;
    logic              io_hit_s;
    logic              misalign_s;
    logic              stall_s;
    logic              err_s;
    logic              unused_s;

    function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Lane pick ignores a[0] for halves, so force-alignment falls out naturally.
    function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = raw[{a, 3'b000} +: 8];
        h = raw[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = raw;
        endcase
        return r;
    endfunction

`ifdef DMEM_MISALIGN_EN
    function automatic logic misalign_f(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    assign misalign_s = misalign_f(core.FUNCT3, core.DIR_DMEM[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Request fields come live from the core in IDLE and from the held copy afterwards.
    assign f3_s     = (state_q == IDLE) ? core.FUNCT3          : f3_q;
    assign addr_s   = (state_q == IDLE) ? core.DIR_DMEM        : addr_q;
    assign wd_s     = (state_q == IDLE) ? core.DATA_WRITE_DMEM : wdata_q;
    assign be_s     = be_f(f3_s, addr_s[1:0]);
    assign wrep_s   = wdata_f(f3_s, wd_s);
    assign req_s    = core.READ | core.WRITE;
    assign io_hit_s = (core.DIR_DMEM[31:16] == IO_BASE[31:16]);
    assign unused_s = ^addr_s;

    assign RAM_ADDR  = addr_s[ADDR_W+1:2];
    assign RAM_WDATA = wrep_s;
    assign RAM_BE    = be_s;
    assign IO_ADDR   = addr_s[7:0];
    assign IO_WDATA  = wrep_s;
    assign IO_BE     = be_s;

    assign core.DATA_READ_DMEM = data_q;
    assign core.STALL          = stall_s;
    assign core.ERR            = err_s;

    // Next-state, strobe and result logic; RSTa gates IDLE strobes so a reset drops them at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        RAM_WE  = 1'b0;
        RAM_RE  = 1'b0;
        IO_REQ  = 1'b0;
        IO_WE   = 1'b0;
        stall_s = 1'b0;
        err_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (RSTa && req_s) begin
                    if (misalign_s) begin
                        err_s = 1'b1;
                        if (!core.WRITE) begin
                            data_d = 32'h0000_0000;
                        end else begin
                            data_d = data_q;
                        end
                    end else if (io_hit_s) begin
                        IO_REQ  = 1'b1;
                        IO_WE   = core.WRITE;
                        stall_s = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = IO_WAIT;
                    end else if (core.WRITE) begin
                        RAM_WE  = 1'b1;
                    end else begin
                        RAM_RE  = 1'b1;
                        stall_s = 1'b1;
                        state_d = RAM_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RAM_RD: begin
                data_d  = load_f(f3_q, addr_q[1:0], RAM_RDATA);
                stall_s = 1'b1;
                state_d = DONE;
            end
            IO_WAIT: begin
                IO_REQ  = 1'b1;
                IO_WE   = we_q;
                stall_s = 1'b1;
                if (IO_ACK) begin
                    if (!we_q) begin
                        data_d = load_f(f3_q, addr_q[1:0], IO_RDATA);
                    end else begin
                        data_d = data_q;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_s   = 1'b1;
                    data_d  = 32'h0000_0000;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timeout counter, load result and the request copy held while stalled.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= 32'h0000_0000;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            if (state_q == IDLE) begin
                f3_q    <= core.FUNCT3;
                addr_q  <= core.DIR_DMEM;
                wdata_q <= core.DATA_WRITE_DMEM;
                we_q    <= core.WRITE;
            end else begin
                f3_q    <= f3_q;
                addr_q  <= addr_q;
                wdata_q <= wdata_q;
                we_q    <= we_q;
            end
        end
    end

endmodule
